// File: rtl/bfp_denormalizer_pkg.sv
// -----------------------------------------------------------------------------
// bfp_pkg -- shared constants and types for the block-floating-point
// denormalizer slice.
//
//   BFP_EXP_SIZE   : FP16 exponent width, also the block shared-exponent width
//   BFP_MANT_SIZE  : FP16 fraction width, also the block mantissa magnitude width
//   BFP_DATA_WIDTH : FP16 output word width
//   BFP_LANES      : mantissas per block (one 3x3 kernel window)
//   FP16_BIAS      : FP16 exponent bias
//   state_e        : denormalizer FSM state encoding
// -----------------------------------------------------------------------------
package bfp_pkg;

   localparam int unsigned BFP_EXP_SIZE   = 5;
   localparam int unsigned BFP_MANT_SIZE  = 10;
   localparam int unsigned BFP_DATA_WIDTH = 16;
   localparam int unsigned BFP_LANES      = 9;
   localparam int unsigned FP16_BIAS      = 15;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/bfp_denormalizer_lzc.sv
// -----------------------------------------------------------------------------
// bfp_lzc -- combinational leading-zero counter for a block mantissa magnitude.
//
//   mag : MANT_SIZE-bit magnitude
//   lz  : number of zeros above the most significant set bit (0..MANT_SIZE-1);
//         an all-zero input returns MANT_SIZE, callers treat zero separately
// -----------------------------------------------------------------------------
module bfp_lzc
   import bfp_pkg::*;
#(
   parameter int unsigned MANT_SIZE = BFP_MANT_SIZE
) (
   input  logic [MANT_SIZE-1:0] mag,
   output logic [3:0]           lz
);

   logic found;

   always_comb begin
      lz    = 4'(MANT_SIZE);
      found = 1'b0;
      for (int unsigned i = 0; i < MANT_SIZE; i++) begin
         if (!found && mag[MANT_SIZE-1-i]) begin
            lz    = 4'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bfp_denormalizer.sv
// -----------------------------------------------------------------------------
// bfp_denormalizer -- converts one block-floating-point block (shared exponent
// plus LANES sign-magnitude mantissas) into LANES FP16 words, one lane per
// output handshake.
//
//   clk, rst_n  : clock (rising edge) and synchronous active-low reset
//   in_valid    : a block is presented on in_exp / in_mant
//   in_ready    : block can be accepted (high only while idle)
//   in_exp      : block shared exponent E
//   in_mant     : LANES x (MANT_SIZE+1) words, lane i at [i*(MANT_SIZE+1) +: ..],
//                 MSB of each word is the sign, the rest is the magnitude m
//   out_valid   : out_data / out_lane / out_last hold a result
//   out_ready   : consumer accepts the current result
//   out_data    : FP16 result
//   out_lane    : lane index of out_data
//   out_last    : out_data is the final lane of the block
//
// Lane value is (-1)^s * m/2^MANT_SIZE * 2^(E-15). Results whose biased
// exponent would be <= 0 are flushed to signed zero, unless the macro
// BFP_DENORM_SUBNORMAL_EN is defined, in which case they become FP16
// subnormals.
// -----------------------------------------------------------------------------
module bfp_denormalizer
   import bfp_pkg::*;
#(
   parameter int unsigned EXP_SIZE   = BFP_EXP_SIZE,
   parameter int unsigned MANT_SIZE  = BFP_MANT_SIZE,
   parameter int unsigned DATA_WIDTH = BFP_DATA_WIDTH,
   parameter int unsigned LANES      = BFP_LANES
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [EXP_SIZE-1:0]              in_exp,
   input  logic [LANES*(MANT_SIZE+1)-1:0]   in_mant,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [3:0]                       out_lane,
   output logic                             out_last
);

   localparam int unsigned WORD_W    = MANT_SIZE + 1;
   localparam logic [3:0]  LAST_LANE = 4'(LANES - 1);

   state_e                    state_q, state_d;
   logic [3:0]                lane_q, lane_d;
   logic [EXP_SIZE-1:0]       exp_q, exp_d;
   logic [LANES*WORD_W-1:0]   mant_q, mant_d;
   logic                      out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
   logic                      out_last_q, out_last_d;

   logic                      accept;
   logic                      hs;
   logic                      is_last;
   logic [3:0]                nxt_lane;

   logic [EXP_SIZE-1:0]       src_exp;
   logic [WORD_W-1:0]         src_word;
   logic                      src_sign;
   logic [MANT_SIZE-1:0]      src_mag;
   logic [3:0]                lz;
   logic [4:0]                lz_p1;
   logic signed [EXP_SIZE+1:0] e_s;
   logic [EXP_SIZE-1:0]       exp_field;
   logic [MANT_SIZE-1:0]      frac_field;
   logic [DATA_WIDTH-1:0]     conv_data;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign hs       = out_valid_q && out_ready;
   assign is_last  = (lane_q == LAST_LANE);
   assign nxt_lane = is_last ? '0 : lane_q + 4'd1;

   // The single converter serves whichever lane gets registered next: lane 0
   // straight from the input port on accept (giving one-cycle latency), else
   // the following lane of the captured block.
   always_comb begin
      if (accept) begin
         src_exp  = in_exp;
         src_word = in_mant[WORD_W-1:0];
      end else begin
         src_exp  = exp_q;
         src_word = mant_q[nxt_lane*WORD_W +: WORD_W];
      end
   end

   assign src_sign = src_word[MANT_SIZE];
   assign src_mag  = src_word[MANT_SIZE-1:0];

   bfp_lzc #(
      .MANT_SIZE (MANT_SIZE)
   ) u_lzc (
      .mag (src_mag),
      .lz  (lz)
   );

   assign lz_p1 = {1'b0, lz} + 5'd1;

   // Biased exponent of the normalised result: E - lz - 1, kept signed and two
   // bits wider so that underflow shows up as a non-positive value.
   assign e_s = $signed({2'b00, src_exp})
              - $signed({{(EXP_SIZE-3){1'b0}}, lz_p1});

   always_comb begin
      exp_field  = '0;
      frac_field = '0;
      if (src_mag == '0) begin
         // signed zero: sign only
      end else if (!e_s[EXP_SIZE+1] && (e_s != '0)) begin
         exp_field  = e_s[EXP_SIZE-1:0];
         // shifting out the leading one leaves the hidden-bit fraction
         frac_field = src_mag << lz_p1;
      end else begin
`ifdef BFP_DENORM_SUBNORMAL_EN
         if (src_exp == '0) begin
            frac_field = src_mag >> 1;
         end else begin
            frac_field = src_mag << (src_exp - 1'b1);
         end
`endif
      end
      conv_data = {src_sign, exp_field, frac_field};
   end

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d     = ST_EMIT;
               exp_d       = in_exp;
               mant_d      = in_mant;
               lane_d      = '0;
               out_valid_d = 1'b1;
               out_data_d  = conv_data;
               out_last_d  = (LAST_LANE == 4'd0);
            end
         end
         ST_EMIT: begin
            if (hs) begin
               if (is_last) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
               end else begin
                  lane_d      = nxt_lane;
                  out_data_d  = conv_data;
                  out_last_d  = (nxt_lane == LAST_LANE);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lane_q      <= '0;
         exp_q       <= '0;
         mant_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_lane  = lane_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_bfp_denormalizer.sv
// -----------------------------------------------------------------------------
// tb_bfp_denormalizer -- directed, table-driven bench for bfp_denormalizer.
// Expected FP16 words are hand-computed; underflow expectations switch on
// BFP_DENORM_SUBNORMAL_EN.
// -----------------------------------------------------------------------------
module tb_bfp_denormalizer;
   import bfp_pkg::*;

   localparam int unsigned L = 9;
   localparam int unsigned W = 11;
   localparam logic [4:0]  E_UNITY = 5'(FP16_BIAS);

   typedef logic [15:0]    exp_arr_t [L];
   typedef logic [L*W-1:0] blk_t;

   typedef struct {
      logic [4:0]  e;
      logic [10:0] w;     // {sign, magnitude}
      logic [15:0] ftz;   // expected with flush-to-zero
      logic [15:0] sub;   // expected with subnormal support
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_exp;
   blk_t        in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_lane;
   logic        out_last;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bfp_denormalizer #(
      .EXP_SIZE   (5),
      .MANT_SIZE  (10),
      .DATA_WIDTH (16),
      .LANES      (9)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_last  (out_last)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a block, wait (bounded) for acceptance, then scramble the inputs
   // so a design that reads them mid-block is caught.
   task automatic send(input logic [4:0] e, input blk_t b);
      int unsigned t = 0;
      in_valid = 1'b1;
      in_exp   = e;
      in_mant  = b;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      chk("send_ready", 32'(in_ready), 1);
      chk("pre_valid", 32'(out_valid), 0);
      step();
      in_valid = 1'b0;
      in_exp   = ~e;
      in_mant  = ~b;
      chk("first_valid", 32'(out_valid), 1);
      chk("first_lane", 32'(out_lane), 0);
   endtask

   // Drain one block. mode 0: always ready; 1: ready toggles 0101..;
   // 2: ready held low for 15 cycles while lane 3 is shown.
   task automatic collect(input exp_arr_t ex, input int mode);
      int unsigned cnt   = 0;
      int unsigned cyc   = 0;
      int unsigned stall = 0;
      logic rdy;
      while (cnt < L && cyc < 200) begin
         case (mode)
            1:       rdy = cyc[0];
            2:       rdy = !(cnt == 3 && stall < 15);
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         if (out_valid) begin
            chk($sformatf("lane@%0d", cnt), 32'(out_lane), cnt);
            chk($sformatf("data@%0d", cnt), 32'(out_data), 32'(ex[cnt]));
            chk($sformatf("last@%0d", cnt), 32'(out_last), 32'(cnt == L-1));
            chk("in_ready_emit", 32'(in_ready), 0);
            if (rdy) cnt++;
            else     stall++;
         end
         step();
         cyc++;
      end
      chk("lanes_done", cnt, L);
      chk("end_valid", 32'(out_valid), 0);
      chk("end_in_ready", 32'(in_ready), 1);
   endtask

   vec_t        vt [13];
   logic [10:0] a_w [L];
   exp_arr_t    ex_a, ex_b, ex_v;
   blk_t        blk_a, blk_b, blk_v;

   initial begin
      vt = '{
         '{E_UNITY, 11'h200, 16'h3800, 16'h3800},
         '{E_UNITY, 11'h300, 16'h3A00, 16'h3A00},
         '{E_UNITY, 11'h001, 16'h1400, 16'h1400},
         '{E_UNITY, 11'h600, 16'hB800, 16'hB800},
         '{E_UNITY, 11'h400, 16'h8000, 16'h8000},
         '{5'd3,    11'h001, 16'h0000, 16'h0004},
         '{5'd31,   11'h3FF, 16'h7BFE, 16'h7BFE},
         '{5'd1,    11'h200, 16'h0000, 16'h0200},
         '{5'd0,    11'h7FF, 16'h8000, 16'h81FF},
         '{5'd2,    11'h200, 16'h0400, 16'h0400},
         '{5'd10,   11'h010, 16'h1000, 16'h1000},
         '{5'd20,   11'h4A5, 16'hC528, 16'hC528},
         '{5'd10,   11'h001, 16'h0000, 16'h0200}
      };
      a_w  = '{11'h200, 11'h700, 11'h001, 11'h100, 11'h480,
               11'h3FF, 11'h400, 11'h002, 11'h040};
      ex_a = '{16'h3800, 16'hBA00, 16'h1400, 16'h3400, 16'hB000,
               16'h3BFE, 16'h8000, 16'h1800, 16'h2C00};
      for (int l = 0; l < L; l++) begin
         blk_a[l*W +: W] = a_w[l];
         blk_b[l*W +: W] = 11'h4A5;
         ex_b[l]         = 16'hC528;
      end

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_lane", 32'(out_lane), 0);
      chk("rst_out_last", 32'(out_last), 0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 1);

      // single-value vectors, replicated across all lanes of a block
      for (int i = 0; i < 13; i++) begin
         for (int l = 0; l < L; l++) begin
            blk_v[l*W +: W] = vt[i].w;
`ifdef BFP_DENORM_SUBNORMAL_EN
            ex_v[l] = vt[i].sub;
`else
            ex_v[l] = vt[i].ftz;
`endif
         end
         send(vt[i].e, blk_v);
         collect(ex_v, 0);
      end

      // mixed lanes with out_ready toggling, then a long stall
      send(E_UNITY, blk_a);
      collect(ex_a, 1);
      send(E_UNITY, blk_a);
      collect(ex_a, 2);

      // reset while lane 4 is presented
      begin
         int unsigned t = 0;
         send(E_UNITY, blk_a);
         out_ready = 1'b1;
         while (!(out_valid && out_lane == 4'd4) && t < 30) begin
            step();
            t++;
         end
         chk("reach_lane4", 32'(out_lane), 4);
         rst_n = 1'b0;
         step();
         chk("midrst_valid", 32'(out_valid), 0);
         chk("midrst_data", 32'(out_data), 0);
         chk("midrst_lane", 32'(out_lane), 0);
         chk("midrst_last", 32'(out_last), 0);
         chk("midrst_in_ready", 32'(in_ready), 1);
         rst_n     = 1'b1;
         out_ready = 1'b0;
         step();
         chk("postrst_valid", 32'(out_valid), 0);
         send(5'd20, blk_b);
         collect(ex_b, 0);
      end

      // in_valid held high across two back-to-back blocks
      in_valid = 1'b1;
      in_exp   = E_UNITY;
      in_mant  = blk_a;
      chk("b2b_ready0", 32'(in_ready), 1);
      step();
      chk("b2b_valid_a", 32'(out_valid), 1);
      in_exp  = 5'd20;
      in_mant = blk_b;
      collect(ex_a, 0);
      step();
      chk("b2b_valid_b", 32'(out_valid), 1);
      chk("b2b_lane_b", 32'(out_lane), 0);
      in_valid = 1'b0;
      in_exp   = '0;
      in_mant  = '0;
      collect(ex_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
